lfsr_prbs_gen: RTL and testbench
================================

Name: lfsr_prbs_gen

Overview:
- Free-running parameterised PRBS generator.
- Holds an LFSR state register and, on each enabled clock, advances it by OUTPUT_WIDTH bit-steps.
- Registers the OUTPUT_WIDTH generated bits on data_out.
- Used as the pattern source for link/serdes test logic, e.g. PRBS31 for 8-bit lanes.

Parameters:
- LFSR_WIDTH, 31: state register width; ≥2.
- LFSR_POLY, 31'h10000001: feedback polynomial, LFSR_WIDTH bits.
  - Bit k (1..W-1) set means term x^k; bit 0 is the constant term.
  - x^W is implicit.
  - Default means x^31+x^28+1.
- LFSR_INIT, all ones: state loaded on reset; must be nonzero.
- LFSR_CONFIG, "FIBONACCI": "FIBONACCI" or "GALOIS".
- REVERSE, 0: 0 = first-generated bit lands in data_out MSB; 1 = first-generated bit lands in data_out LSB.
- OUTPUT_WIDTH, 8: bits produced per enabled cycle; ≥1, may exceed LFSR_WIDTH.
- STYLE, "AUTO": "AUTO", "LOOP" or "REDUCTION". Selects implementation only; it is never functional.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous active-high reset.
- enable, input, 1: advance generator this cycle.
- data_out, output, OUTPUT_WIDTH: registered PRBS bits.

Behaviour:
- Reset (rst=1 at clk edge): state <= LFSR_INIT; data_out <= 0. Reset has priority over enable.
- enable=0: state and data_out hold.
- enable=1: perform OUTPUT_WIDTH single-bit steps combinationally from the current state.
  - state <= state after OUTPUT_WIDTH steps.
  - data_out <= the OUTPUT_WIDTH step output bits.
  - Latency: the bits appear on data_out the cycle after the enabled edge.
- Fibonacci step:
  - fb = state[W-1] XOR (XOR of state[k-1] for each k in 1..W-1 with LFSR_POLY[k]=1).
  - out = fb; state <= {state[W-2:0], fb}.
  - PRBS31 case: fb = state[30]^state[27].
- Galois step:
  - out = state[W-1].
  - state <= {state[W-2:0], 0} XOR (out ? LFSR_POLY : 0).
- Bit ordering, REVERSE=0: step 1 output -> data_out[OUTPUT_WIDTH-1], step N -> data_out[0].
- Bit ordering, REVERSE=1: step 1 -> data_out[0].
- Stream continuity: consecutive enabled words form one continuous bit sequence with no gaps; disabled cycles insert no bits.
- Period: maximal-length polys give period 2^W-1 bits, independent of OUTPUT_WIDTH.
- All-zero state: locks up; LFSR_INIT=0 is illegal.
- Mid-run reset: restarts the sequence from LFSR_INIT on the next cycle.
- Implementation: the multi-step update is a constant XOR matrix derived from the parameters at elaboration. No multicycle logic, no combinational path from enable to data_out.

Optional Feature:
- Macro LFSR_PRBS_GEN_INVERT_EN.
- Defined: data_out is the bitwise inverse of the generated bits (ITU-T O.150 polarity). The reset value of data_out stays 0, and state is unaffected.
- Undefined: data_out carries the true generated bits as above.

Decomposition:
- Shared package lfsr_pkg holds:
  - config string constants FIBONACCI and GALOIS;
  - standard polynomial constants: PRBS7 7'h41, PRBS9 9'h021, PRBS15 15'h4001, PRBS23 23'h040001, PRBS31 31'h10000001.
- One natural sub-module, lfsr_step: purely combinational OUTPUT_WIDTH-step LFSR (state_in -> state_out, data_out) with the same parameters. lfsr_prbs_gen registers around it.

Test Plan:
- Reset then hold enable=0 for 10 cycles -> data_out=8'h00 and state=31'h7FFFFFFF constant.
- Default PRBS31 after reset, enable=1 for 4 cycles -> data_out sequence 8'h00, 8'h00, 8'h00, 8'h0E.
- Same run with REVERSE=1 -> 8'h00, 8'h00, 8'h00, 8'h70.
- Toggle enable 1,0,1,0 -> concatenated enabled words match the continuous software-model bit stream. With the generator already running (not from the first word after reset), data_out holds during the low cycles.
- Reset asserted mid-run for one cycle with enable=1 -> data_out=0, then the sequence restarts at 8'h00, 8'h00, 8'h00, 8'h0E.
- Sweep configs against a bit-serial software model:
  - PRBS7 (W=7, POLY 7'h41) in FIBONACCI and GALOIS, OUTPUT_WIDTH 1, 8 and 16;
  - run 127 steps -> sequence repeats with period 127 and never hits the all-zero state.
  - Also run with LFSR_PRBS_GEN_INVERT_EN defined -> words are exact inverses of the undefined-build words.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared LFSR configuration names and standard PRBS polynomials
package lfsr_pkg;
  localparam string FIBONACCI = "FIBONACCI";
  localparam string GALOIS = "GALOIS";
  localparam logic [6:0] PRBS7 = 7'h41;
  localparam logic [8:0] PRBS9 = 9'h021;
  localparam logic [14:0] PRBS15 = 15'h4001;
  localparam logic [22:0] PRBS23 = 23'h040001;
  localparam logic [30:0] PRBS31 = 31'h10000001;
endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: combinational OUTPUT_WIDTH-step LFSR advance (STYLE "LOOP" unrolls, otherwise a precomputed XOR matrix)
module lfsr_step import lfsr_pkg::*; #(
  parameter int LFSR_WIDTH = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY = LFSR_WIDTH'(PRBS31),
  parameter string LFSR_CONFIG = FIBONACCI,
  parameter int REVERSE = 0,
  parameter int OUTPUT_WIDTH = 8,
  parameter string STYLE = "AUTO"
) (
  input logic [LFSR_WIDTH-1:0] state_in,
  output logic [LFSR_WIDTH-1:0] state_out,
  output logic [OUTPUT_WIDTH-1:0] data_out
);
  localparam int W = LFSR_WIDTH;
  localparam int N = OUTPUT_WIDTH;
  localparam bit GAL = LFSR_CONFIG == GALOIS;
  typedef logic [W+N-1:0][W-1:0] mat_t;
  // Rows 0..N-1 are output-bit masks, rows N..N+W-1 next-state masks, all over state_in
  function automatic mat_t build();
    logic [W-1:0][W-1:0] s;
    logic [W-1:0] o;
    mat_t m;
    m = '0;
    for (int i = 0; i < W; i++) begin
      s[i] = '0;
      s[i][i] = 1'b1;
    end
    for (int n = 0; n < N; n++) begin
      o = s[W-1];
      if (!GAL)
        for (int k = 1; k < W; k++)
          if (LFSR_POLY[k]) o ^= s[k-1];
      for (int i = W - 1; i > 0; i--)
        s[i] = GAL ? (s[i-1] ^ (LFSR_POLY[i] ? o : '0)) : s[i-1];
      s[0] = GAL ? (LFSR_POLY[0] ? o : '0) : o;
      m[REVERSE != 0 ? n : N-1-n] = o;
    end
    for (int i = 0; i < W; i++) m[N+i] = s[i];
    return m;
  endfunction
  localparam mat_t M = build();
  if (STYLE == "LOOP") begin : g_loop
    logic [W-1:0] s;
    logic o;
    always_comb begin
      s = state_in;
      o = 1'b0;
      data_out = '0;
      for (int n = 0; n < N; n++) begin
        o = GAL ? s[W-1] : s[W-1] ^ (^(s[W-2:0] & LFSR_POLY[W-1:1]));
        s = GAL ? ({s[W-2:0], 1'b0} ^ (o ? LFSR_POLY : '0)) : {s[W-2:0], o};
        data_out[REVERSE != 0 ? n : N-1-n] = o;
      end
      state_out = s;
    end
  end else begin : g_red
    for (genvar i = 0; i < W; i++) begin : g_s
      assign state_out[i] = ^(state_in & M[N+i]);
    end
    for (genvar j = 0; j < N; j++) begin : g_d
      assign data_out[j] = ^(state_in & M[j]);
    end
  end
endmodule

// File: rtl/lfsr_prbs_gen.sv
// lfsr_prbs_gen: registered PRBS generator around lfsr_step
// LFSR_PRBS_GEN_INVERT_EN: when defined, data_out carries inverted PRBS bits (reset value still 0)
module lfsr_prbs_gen import lfsr_pkg::*; #(
  parameter int LFSR_WIDTH = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY = LFSR_WIDTH'(PRBS31),
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT = '1,
  parameter string LFSR_CONFIG = FIBONACCI,
  parameter int REVERSE = 0,
  parameter int OUTPUT_WIDTH = 8,
  parameter string STYLE = "AUTO"
) (
  input logic clk,
  input logic rst,
  input logic enable,
  output logic [OUTPUT_WIDTH-1:0] data_out
);
  logic [LFSR_WIDTH-1:0] state;
  logic [LFSR_WIDTH-1:0] state_nxt;
  logic [OUTPUT_WIDTH-1:0] bits;
  logic [OUTPUT_WIDTH-1:0] word;
  lfsr_step #(
    .LFSR_WIDTH(LFSR_WIDTH),
    .LFSR_POLY(LFSR_POLY),
    .LFSR_CONFIG(LFSR_CONFIG),
    .REVERSE(REVERSE),
    .OUTPUT_WIDTH(OUTPUT_WIDTH),
    .STYLE(STYLE)
  ) u_step (
    .state_in(state),
    .state_out(state_nxt),
    .data_out(bits)
  );
`ifdef LFSR_PRBS_GEN_INVERT_EN
  assign word = ~bits;
`else
  assign word = bits;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LFSR_INIT;
      data_out <= '0;
    end else if (enable) begin
      state <= state_nxt;
      data_out <= word;
    end
  end
endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// tb_lfsr_prbs_gen: directed checks of PRBS31 and PRBS7 configurations against a bit-serial model
module tb_lfsr_prbs_gen;
  import lfsr_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic [15:0] dout [8];
  logic [31:0] st [8];
  logic [7:0] d0, d1;
  int ncmp = 0;
  int nfail = 0;
  localparam int CW [8] = '{31, 31, 7, 7, 7, 7, 7, 7};
  localparam int CN [8] = '{8, 8, 1, 8, 16, 1, 8, 16};
  localparam bit CG [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
  localparam bit CR [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
  localparam logic [31:0] CP [8] = '{32'h10000001, 32'h10000001, 32'h41, 32'h41, 32'h41, 32'h41, 32'h41, 32'h41};
  logic [31:0] ms [8];
  logic [15:0] ex [8];
  logic [15:0] fw [8];
  logic [15:0] held;
  always #5 clk = ~clk;

  lfsr_prbs_gen u_def (.clk(clk), .rst(rst), .enable(enable), .data_out(d0));
  lfsr_prbs_gen #(.REVERSE(1)) u_rev (.clk(clk), .rst(rst), .enable(enable), .data_out(d1));
  assign dout[0] = 16'(d0);
  assign dout[1] = 16'(d1);
  assign st[0] = 32'(u_def.state);
  assign st[1] = 32'(u_rev.state);
  for (genvar g = 0; g < 6; g++) begin : g7
    localparam int N = (g % 3 == 0) ? 1 : (g % 3 == 1) ? 8 : 16;
    logic [N-1:0] d;
    lfsr_prbs_gen #(
      .LFSR_WIDTH(7),
      .LFSR_POLY(PRBS7),
      .LFSR_CONFIG(g >= 3 ? GALOIS : FIBONACCI),
      .OUTPUT_WIDTH(N),
      .STYLE(g == 1 ? "LOOP" : "AUTO")
    ) u (.clk(clk), .rst(rst), .enable(enable), .data_out(d));
    assign dout[g+2] = 16'(d);
    assign st[g+2] = 32'(u.state);
  end

  function automatic logic [32:0] step1(input int w, input logic [31:0] poly, input bit gal, input logic [31:0] s);
    logic [31:0] mask;
    logic o;
    mask = 32'((64'd1 << w) - 1);
    o = s[w-1];
    if (!gal)
      for (int k = 1; k < w; k++)
        if (poly[k]) o ^= s[k-1];
    if (gal) return {o, ((s << 1) & mask) ^ (o ? poly : 32'h0)};
    return {o, ((s << 1) | 32'(o)) & mask};
  endfunction

  function automatic logic [47:0] gen(input int i, input logic [31:0] s);
    logic [15:0] d;
    logic [32:0] r;
    d = '0;
    for (int k = 0; k < CN[i]; k++) begin
      r = step1(CW[i], CP[i], CG[i], s);
      s = r[31:0];
      d[CR[i] ? k : CN[i]-1-k] = r[32];
    end
`ifdef LFSR_PRBS_GEN_INVERT_EN
    d = ~d & 16'((32'd1 << CN[i]) - 1);
`endif
    return {d, s};
  endfunction

  function automatic logic [7:0] pol(input logic [7:0] x);
`ifdef LFSR_PRBS_GEN_INVERT_EN
    return ~x;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    ncmp++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic cycle();
    logic [47:0] r;
    @(posedge clk);
    for (int i = 0; i < 8; i++)
      if (rst) begin
        ms[i] = 32'((64'd1 << CW[i]) - 1);
        ex[i] = '0;
      end else if (enable) begin
        r = gen(i, ms[i]);
        ms[i] = r[31:0];
        ex[i] = r[47:32];
      end
    #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("data%0d", i), 32'(dout[i]), 32'(ex[i]));
      chk($sformatf("state%0d", i), st[i], ms[i]);
    end
  endtask

  initial begin
    logic [7:0] h [4];
    logic [7:0] hr [4];
    h = '{8'h00, 8'h00, 8'h00, 8'h0E};
    hr = '{8'h00, 8'h00, 8'h00, 8'h70};
    rst = 1'b1;
    enable = 1'b0;
    cycle();
    cycle();
    chk("reset_data", 32'(d0), 32'h0);
    chk("reset_state", st[0], 32'h7FFFFFFF);
    rst = 1'b0;
    repeat (10) begin
      cycle();
      chk("idle_data", 32'(d0), 32'h0);
      chk("idle_state", st[0], 32'h7FFFFFFF);
    end
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk($sformatf("prbs31_w%0d", k), 32'(d0), 32'(pol(h[k])));
      chk($sformatf("prbs31_rev_w%0d", k), 32'(d1), 32'(pol(hr[k])));
    end
    for (int k = 0; k < 6; k++) begin
      enable = k[0];
      held = ex[0];
      cycle();
      if (!enable) chk("hold_low", 32'(d0), 32'(held));
    end
    enable = 1'b1;
    cycle();
    rst = 1'b1;
    cycle();
    chk("midrst_data", 32'(d0), 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk($sformatf("restart_w%0d", k), 32'(d0), 32'(pol(h[k])));
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 127; k++) begin
      cycle();
      if (k == 0) fw = ex;
      for (int i = 2; i < 8; i++) begin
        ncmp++;
        assert (st[i] !== 32'h0) else begin
          nfail++;
          $error("FAIL lockup%0d observed=%h expected=nonzero", i, st[i]);
        end
      end
    end
    for (int i = 2; i < 8; i++) chk($sformatf("period_state%0d", i), st[i], 32'h7F);
    cycle();
    for (int i = 2; i < 8; i++) chk($sformatf("period_word%0d", i), 32'(dout[i]), 32'(fw[i]));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
